sram_ctrl_multi: RTL and testbench

- Parametrised asynchronous-SRAM controller on the Wishbone-style slave bus. Drives CHIPS parallel 16-bit SRAM devices as one (16*CHIPS)-bit word.
- Generalises the fixed 3-chip controller with:
  - configurable chip count and address width;
  - programmable read-wait, write setup/pulse/hold and write-to-next turnaround cycles;
  - per-chip chip-enable gating on partial writes;
  - an explicit one-cycle completion strobe (wb_ack) and a registered read-data output.
- Sits between the bus interconnect and the board SRAM pins.

---
 rtl/sram_ctrl_multi.sv | 228 ++++++++++++++++++++++
 tb/tb_sram_ctrl_multi.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_multi.sv
// sram_ctrl_multi: Wishbone-style slave controller for CHIPS parallel 16-bit
// asynchronous SRAMs. The devices are accessed together as one (16*CHIPS)-bit word.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   sram_ce/oe/we/ub/lb_n      per-device active-low strobes (registered)
//   sram_addr                  shared device address (registered)
//   sram_data                  shared data bus; chip c owns bits [16c+15:16c]
//   wb_stb, wb_addr            request strobe and byte address (one word per 4 bytes)
//   wb_we, wb_din              byte write enables (all-zero = read) and write data
//   wb_dout                    registered read data, held until the next read completes
//   wb_ack                     one-cycle completion pulse
//   wb_nak                     busy flag; high in every non-idle state
module sram_ctrl_multi #(
    parameter int CHIPS    = 3,
    parameter int ADDR_W   = 20,
    parameter int RD_WAIT  = 5,
    parameter int WR_SETUP = 2,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1,
    parameter int TURN     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [CHIPS-1:0]      sram_ce_n,
    output logic [CHIPS-1:0]      sram_oe_n,
    output logic [CHIPS-1:0]      sram_we_n,
    output logic [CHIPS-1:0]      sram_ub_n,
    output logic [CHIPS-1:0]      sram_lb_n,
    output logic [ADDR_W-1:0]     sram_addr,
    inout  wire  [16*CHIPS-1:0]   sram_data,
    input  logic                  wb_stb,
    input  logic [31:0]           wb_addr,
    input  logic [2*CHIPS-1:0]    wb_we,
    input  logic [16*CHIPS-1:0]   wb_din,
    output logic [16*CHIPS-1:0]   wb_dout,
    output logic                  wb_ack,
    output logic                  wb_nak
);

    localparam int DW = 16 * CHIPS;
    localparam int BW = 2 * CHIPS;

    // Counters are loaded with (cycles - 1) and the state advances when they reach zero.
    localparam logic [3:0] C_RD   = 4'(RD_WAIT - 1);
    localparam logic [3:0] C_SU   = 4'(WR_SETUP - 1);
    localparam logic [3:0] C_PL   = 4'(WR_PULSE - 1);
    localparam logic [3:0] C_HD   = 4'(WR_HOLD - 1);
    localparam logic [3:0] C_TURN = 4'(TURN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_DONE, S_WR_SU, S_WR_PL, S_WR_HD, S_WR_DONE, S_TURN_W
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_accept;

    logic [ADDR_W-1:0]     r_lat_addr;
    logic [BW-1:0]         r_lat_we;
    logic [DW-1:0]         r_lat_din;
    logic [ADDR_W-1:0]     w_lat_addr;
    logic [BW-1:0]         w_lat_we;

    logic [CHIPS-1:0]      w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_drv;
    logic                  r_drv;

    // Address bits outside the word index carry no meaning for this memory.
    logic                  w_unused_addr;
    assign w_unused_addr = ^{wb_addr[31:ADDR_W+2], wb_addr[1:0]};

    function automatic logic [CHIPS-1:0] f_active(input logic [BW-1:0] we);
        logic [CHIPS-1:0] act;
        for (int c = 0; c < CHIPS; c++) act[c] = we[2*c] | we[2*c+1];
        return act;
    endfunction

    function automatic logic [CHIPS-1:0] f_upper(input logic [BW-1:0] we);
        logic [CHIPS-1:0] ub;
        for (int c = 0; c < CHIPS; c++) ub[c] = we[2*c+1];
        return ub;
    endfunction

    function automatic logic [CHIPS-1:0] f_lower(input logic [BW-1:0] we);
        logic [CHIPS-1:0] lb;
        for (int c = 0; c < CHIPS; c++) lb[c] = we[2*c];
        return lb;
    endfunction

    // Next state and counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wb_stb) begin
                    w_accept = 1'b1;
                    if (|wb_we) begin
                        w_state_nxt = S_WR_SU;
                        w_cnt_nxt   = C_SU;
                    end else begin
                        w_state_nxt = S_RD;
                        w_cnt_nxt   = C_RD;
                    end
                end
            end
            S_RD: begin
                if (r_cnt == 4'd0) w_state_nxt = S_RD_DONE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            S_RD_DONE: w_state_nxt = S_IDLE;
            S_WR_SU: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_WR_PL;
                    w_cnt_nxt   = C_PL;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_WR_PL: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_WR_HD;
                    w_cnt_nxt   = C_HD;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_WR_HD: begin
                if (r_cnt == 4'd0) w_state_nxt = S_WR_DONE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            S_WR_DONE: begin
                if (TURN == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_TURN_W;
                    w_cnt_nxt   = C_TURN;
                end
            end
            S_TURN_W: begin
                if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pins are registered, so they are decoded from the state being entered and
    // from the request fields as they will be latched at this edge.
    assign w_lat_addr = w_accept ? wb_addr[ADDR_W+1:2] : r_lat_addr;
    assign w_lat_we   = w_accept ? wb_we : r_lat_we;

    always_comb begin
        w_ce_n = '1;
        w_oe_n = '1;
        w_we_n = '1;
        w_ub_n = '1;
        w_lb_n = '1;
        w_addr = '0;
        w_drv  = 1'b0;
        case (w_state_nxt)
            S_RD: begin
                w_ce_n = '0;
                w_oe_n = '0;
                w_ub_n = '0;
                w_lb_n = '0;
                w_addr = w_lat_addr;
            end
            S_WR_SU, S_WR_PL, S_WR_HD: begin
                w_ce_n = ~f_active(w_lat_we);
                w_ub_n = ~f_upper(w_lat_we);
                w_lb_n = ~f_lower(w_lat_we);
                w_addr = w_lat_addr;
                w_drv  = 1'b1;
                if (w_state_nxt == S_WR_PL) w_we_n = ~f_active(w_lat_we);
            end
            default: ;
        endcase
    end

    // Request fields: held stable for the whole operation, never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lat_addr <= wb_addr[ADDR_W+1:2];
            r_lat_we   <= wb_we;
            r_lat_din  <= wb_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            sram_ce_n <= '1;
            sram_oe_n <= '1;
            sram_we_n <= '1;
            sram_ub_n <= '1;
            sram_lb_n <= '1;
            sram_addr <= '0;
            r_drv     <= 1'b0;
            wb_dout   <= '0;
            wb_ack    <= 1'b0;
            wb_nak    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            sram_ce_n <= w_ce_n;
            sram_oe_n <= w_oe_n;
            sram_we_n <= w_we_n;
            sram_ub_n <= w_ub_n;
            sram_lb_n <= w_lb_n;
            sram_addr <= w_addr;
            r_drv     <= w_drv;
            wb_ack    <= (w_state_nxt == S_RD_DONE) || (w_state_nxt == S_WR_DONE);
            wb_nak    <= (w_state_nxt != S_IDLE);
            // Sample the bus at the last edge of the read-wait window.
            if (r_state == S_RD && r_cnt == 4'd0) wb_dout <= sram_data;
        end
    end

    assign sram_data = r_drv ? r_lat_din : {DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_multi.sv
module tb_sram_ctrl_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mem_clr;
    int   checks   = 0;
    int   failures = 0;

    // DUT A: default parameters (3 chips, 20 address bits)
    logic [2:0]  a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n;
    logic [19:0] a_addr;
    wire  [47:0] a_data;
    logic        a_stb;
    logic [31:0] a_waddr;
    logic [5:0]  a_wwe;
    logic [47:0] a_din, a_dout;
    logic        a_ack, a_nak;

    // DUT B: 2 chips, 18 address bits, 1-cycle read wait, no turnaround
    logic [1:0]  b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;
    logic [17:0] b_addr;
    wire  [31:0] b_data;
    logic        b_stb;
    logic [31:0] b_waddr;
    logic [3:0]  b_wwe;
    logic [31:0] b_din, b_dout;
    logic        b_ack, b_nak;

    sram_ctrl_multi u_a (
        .clk(clk), .rst(rst),
        .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n),
        .sram_ub_n(a_ub_n), .sram_lb_n(a_lb_n), .sram_addr(a_addr), .sram_data(a_data),
        .wb_stb(a_stb), .wb_addr(a_waddr), .wb_we(a_wwe), .wb_din(a_din),
        .wb_dout(a_dout), .wb_ack(a_ack), .wb_nak(a_nak)
    );

    sram_ctrl_multi #(.CHIPS(2), .ADDR_W(18), .RD_WAIT(1), .TURN(0)) u_b (
        .clk(clk), .rst(rst),
        .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
        .sram_ub_n(b_ub_n), .sram_lb_n(b_lb_n), .sram_addr(b_addr), .sram_data(b_data),
        .wb_stb(b_stb), .wb_addr(b_waddr), .wb_we(b_wwe), .wb_din(b_din),
        .wb_dout(b_dout), .wb_ack(b_ack), .wb_nak(b_nak)
    );

    // Asynchronous SRAM device models (256 words visible)
    logic [47:0] a_mem [0:255];
    logic [31:0] b_mem [0:255];

    for (genvar c = 0; c < 3; c++) begin : g_a_dev
        assign a_data[16*c +: 16] = (!a_ce_n[c] && !a_oe_n[c] && a_we_n[c]) ?
                                    a_mem[a_addr[7:0]][16*c +: 16] : 16'hzzzz;
    end
    for (genvar c = 0; c < 2; c++) begin : g_b_dev
        assign b_data[16*c +: 16] = (!b_ce_n[c] && !b_oe_n[c] && b_we_n[c]) ?
                                    b_mem[b_addr[7:0]][16*c +: 16] : 16'hzzzz;
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (!a_ce_n[c] && !a_we_n[c]) begin
                    if (!a_lb_n[c]) a_mem[a_addr[7:0]][16*c +: 8]   <= a_data[16*c +: 8];
                    if (!a_ub_n[c]) a_mem[a_addr[7:0]][16*c+8 +: 8] <= a_data[16*c+8 +: 8];
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (!b_ce_n[c] && !b_we_n[c]) begin
                    if (!b_lb_n[c]) b_mem[b_addr[7:0]][16*c +: 8]   <= b_data[16*c +: 8];
                    if (!b_ub_n[c]) b_mem[b_addr[7:0]][16*c+8 +: 8] <= b_data[16*c+8 +: 8];
                end
            end
        end
    end

    // Reference memories: what a reader should see after the completed writes
    logic [47:0] ra_mem [0:255];
    logic [31:0] rb_mem [0:255];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on DUT A with a cycle-by-cycle pin check. Cycle k counts
    // clock periods after the accepting edge.
    task automatic a_txn(input string tag, input logic [5:0] we, input int word,
                         input logic [47:0] din, input bit scramble);
        logic        wr;
        logic [2:0]  act, ubx, lbx, e_ce, e_oe, e_we, e_ub, e_lb;
        logic [19:0] e_addr;
        logic [47:0] exp_rd;
        logic        inw;
        int          busy;
        wr = |we;
        for (int c = 0; c < 3; c++) begin
            act[c] = we[2*c] | we[2*c+1];
            ubx[c] = ~we[2*c+1];
            lbx[c] = ~we[2*c];
        end
        busy   = wr ? 7 : 6;
        exp_rd = ra_mem[word];
        @(negedge clk);
        a_stb   = 1'b1;
        a_wwe   = we;
        a_din   = din;
        a_waddr = ($urandom & 32'hFFC0_0000) | (32'(word) << 2) | ($urandom & 32'h3);
        for (int k = 1; k <= busy + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (scramble) begin
                    a_din   = 48'({$urandom, $urandom});
                    a_waddr = $urandom;
                    a_wwe   = 6'($urandom);
                end else begin
                    a_stb = 1'b0;
                end
            end
            if (k == busy + 1) a_stb = 1'b0;
            inw    = (k <= 5);
            e_ce   = inw ? (wr ? ~act : 3'b000) : 3'b111;
            e_oe   = (!wr && inw) ? 3'b000 : 3'b111;
            e_we   = (wr && (k == 3 || k == 4)) ? ~act : 3'b111;
            e_ub   = inw ? (wr ? ubx : 3'b000) : 3'b111;
            e_lb   = inw ? (wr ? lbx : 3'b000) : 3'b111;
            e_addr = inw ? 20'(word) : 20'd0;
            chk($sformatf("%s_pins_c%0d", tag, k),
                64'({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n, a_addr, a_ack, a_nak}),
                64'({e_ce, e_oe, e_we, e_ub, e_lb, e_addr, (k == 6), (k <= busy)}));
            if (wr && inw) chk($sformatf("%s_bus_c%0d", tag, k), 64'(a_data), 64'(din));
            if (!wr && k == 6) chk($sformatf("%s_rdata", tag), 64'(a_dout), 64'(exp_rd));
        end
        if (wr)
            for (int i = 0; i < 6; i++)
                if (we[i]) ra_mem[word][8*i +: 8] = din[8*i +: 8];
    endtask

    // One transaction on DUT B; checks ack latency and read data.
    task automatic b_txn(input string tag, input logic [3:0] we, input int word,
                         input logic [31:0] din);
        logic        wr;
        logic [31:0] exp_rd;
        int          got;
        wr     = |we;
        exp_rd = rb_mem[word];
        got    = 0;
        @(negedge clk);
        b_stb   = 1'b1;
        b_wwe   = we;
        b_din   = din;
        b_waddr = ($urandom & 32'hFFF0_0000) | (32'(word) << 2) | ($urandom & 32'h3);
        @(negedge clk);
        b_stb = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (b_ack) begin
                got = k;
                if (!wr) chk($sformatf("%s_rdata", tag), 64'(b_dout), 64'(exp_rd));
                break;
            end
        end
        chk($sformatf("%s_latency", tag), 64'(got), 64'(wr ? 6 : 2));
        if (wr)
            for (int i = 0; i < 4; i++)
                if (we[i]) rb_mem[word][8*i +: 8] = din[8*i +: 8];
    endtask

    initial begin
        logic [47:0] d48;
        logic [31:0] d32;
        logic [5:0]  we6;
        logic [3:0]  we4;
        logic [15:0] ackmask;
        int          ackcnt;

        rst     = 1'b1;
        mem_clr = 1'b1;
        a_stb = 1'b0; a_waddr = '0; a_wwe = '0; a_din = '0;
        b_stb = 1'b0; b_waddr = '0; b_wwe = '0; b_din = '0;
        for (int i = 0; i < 256; i++) begin
            ra_mem[i] = '0;
            rb_mem[i] = '0;
        end
        repeat (2) @(negedge clk);

        // Reset state of both instances
        chk("a_reset_pins", 64'({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n, a_addr, a_ack, a_nak}),
            64'({15'h7FFF, 20'd0, 1'b0, 1'b0}));
        chk("a_reset_dout", 64'(a_dout), 64'd0);
        chk("b_reset_pins", 64'({b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n, b_addr, b_ack, b_nak}),
            64'({10'h3FF, 18'd0, 1'b0, 1'b0}));
        chk("b_reset_dout", 64'(b_dout), 64'd0);
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Full write to byte address 0x10 (word 4), then read it back
        a_txn("a_wr_full", 6'h3F, 4, 48'h1234_5678_9ABC, 1'b1);
        a_txn("a_rd_full", 6'h00, 4, 48'h0, 1'b0);
        chk("a_dout_held", 64'(a_dout), 64'h1234_5678_9ABC);

        // Partial write touching only byte 2 (chip 1 lower byte)
        a_txn("a_wr_part", 6'b000100, 4, 48'hFFFF_FFFF_FFFF, 1'b0);
        a_txn("a_rd_part", 6'h00, 4, 48'h0, 1'b0);
        chk("a_part_byte", 64'(a_dout), 64'h1234_56FF_9ABC);

        // Randomized mixed traffic, some with bus activity during busy cycles
        for (int n = 0; n < 14; n++) begin
            we6 = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom);
            d48 = 48'({$urandom, $urandom});
            a_txn($sformatf("a_rand%0d", n), we6, $urandom_range(0, 15), d48, n[0]);
        end

        // Known non-zero word for the held-strobe read
        a_txn("a_wr_w60", 6'h3F, 60, 48'hC0DE_0000_BEEF, 1'b0);

        // Strobe held across a write then a read; bus fields change mid-write
        d48 = 48'({$urandom, $urandom}) | 48'h1;
        ackmask = '0;
        @(negedge clk);
        a_stb = 1'b1; a_wwe = 6'h3F; a_waddr = 32'd50 << 2; a_din = d48;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_wwe   = 6'h00;
                a_waddr = 32'd60 << 2;
                a_din   = ~d48;
            end
            if (a_ack) ackmask[k] = 1'b1;
            if (k <= 5) begin
                chk($sformatf("a_hold_addr_c%0d", k), 64'(a_addr), 64'd50);
                chk($sformatf("a_hold_bus_c%0d", k), 64'(a_data), 64'(d48));
            end
            if (k == 8) chk("a_hold_idle", 64'(a_nak), 64'd0);
            if (k == 9) begin
                chk("a_hold_rd_start", 64'({a_oe_n, a_addr, a_nak}), 64'({3'b000, 20'd60, 1'b1}));
                a_stb = 1'b0;
            end
            if (k == 14) chk("a_hold_rdata", 64'(a_dout), 64'(ra_mem[60]));
        end
        chk("a_hold_acks", 64'(ackmask), 64'((16'd1 << 6) | (16'd1 << 14)));
        ra_mem[50] = d48;

        // Reset during the second write-pulse cycle
        @(negedge clk);
        a_stb = 1'b1; a_wwe = 6'h3F; a_waddr = 32'd200 << 2; a_din = 48'hA5A5_5A5A_0F0F;
        @(negedge clk);
        a_stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_abort_pulse", 64'(a_we_n), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("a_abort_pins", 64'({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n, a_addr, a_ack, a_nak}),
            64'({15'h7FFF, 20'd0, 1'b0, 1'b0}));
        chk("a_abort_dout", 64'(a_dout), 64'd0);
        rst = 1'b0;
        ackcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (a_ack || a_nak) ackcnt++;
        end
        chk("a_abort_quiet", 64'(ackcnt), 64'd0);
        a_txn("a_rd_w50", 6'h00, 50, 48'h0, 1'b0);

        // DUT B: back-to-back write then read with the strobe held
        d32 = $urandom | 32'h1;
        ackmask = '0;
        @(negedge clk);
        b_stb = 1'b1; b_wwe = 4'hF; b_waddr = 32'd9 << 2; b_din = d32;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b_wwe = 4'h0;
                b_din = ~d32;
            end
            if (b_ack) ackmask[k] = 1'b1;
            if (k == 7) chk("b_b2b_idle", 64'(b_nak), 64'd0);
            if (k == 8) b_stb = 1'b0;
            if (k == 9) chk("b_b2b_rdata", 64'(b_dout), 64'(d32));
        end
        chk("b_b2b_acks", 64'(ackmask), 64'((16'd1 << 6) | (16'd1 << 9)));
        rb_mem[9] = d32;

        b_txn("b_rd_w9", 4'h0, 9, 32'h0);
        for (int n = 0; n < 10; n++) begin
            we4 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            b_txn($sformatf("b_rand%0d", n), we4, $urandom_range(0, 7), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
